// File: rtl/demux_32_1_2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes and a one-entry register per output.
// Define DEMUX_CNT_EN to build the per-output transfer counters; otherwise cnt_0/cnt_1 read as zero.
module demux_32_1_2_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_0_valid,
  input  logic             out_0_ready,
  output logic [WIDTH-1:0] out_0_data,
  output logic             out_1_valid,
  input  logic             out_1_ready,
  output logic [WIDTH-1:0] out_1_data,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

  chan_state_t state_0_q, state_0_d;
  chan_state_t state_1_q, state_1_d;

  logic acc;
  logic load_0, load_1;
  logic drain_0, drain_1;

  assign out_0_valid = (state_0_q == FULL);
  assign out_1_valid = (state_1_q == FULL);

  assign drain_0 = out_0_valid & out_0_ready;
  assign drain_1 = out_1_valid & out_1_ready;

  // A full channel can still accept when its consumer drains in the same cycle.
  assign in_ready = in_sel ? (~out_1_valid | out_1_ready) : (~out_0_valid | out_0_ready);
  assign acc      = in_valid & in_ready;
  assign load_0   = acc & ~in_sel;
  assign load_1   = acc & in_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_0_q <= EMPTY;
      state_1_q <= EMPTY;
    end else begin
      state_0_q <= state_0_d;
      state_1_q <= state_1_d;
    end
  end

  always_comb begin
    state_0_d = state_0_q;
    state_1_d = state_1_q;
    case (state_0_q)
      EMPTY:   if (load_0) state_0_d = FULL;
      FULL:    if (drain_0 && !load_0) state_0_d = EMPTY;
      default: state_0_d = EMPTY;
    endcase
    case (state_1_q)
      EMPTY:   if (load_1) state_1_d = FULL;
      FULL:    if (drain_1 && !load_1) state_1_d = EMPTY;
      default: state_1_d = EMPTY;
    endcase
  end

  // Data keeps its last value after a drain; only a load replaces it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_0_data <= '0;
      out_1_data <= '0;
    end else begin
      if (load_0) out_0_data <= in_data;
      if (load_1) out_1_data <= in_data;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_0 <= '0;
      cnt_1 <= '0;
    end else begin
      if (drain_0) cnt_0 <= cnt_0 + 1'b1;
      if (drain_1) cnt_1 <= cnt_1 + 1'b1;
    end
  end
`else
  assign cnt_0 = '0;
  assign cnt_1 = '0;
`endif

endmodule

// File: tb/tb_demux_32_1_2_reg.sv
// Self-checking bench for demux_32_1_2_reg: directed scenarios followed by random traffic
// compared against a per-channel behavioural model.
module tb_demux_32_1_2_reg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out_0_valid;
  logic             out_0_ready;
  logic [WIDTH-1:0] out_0_data;
  logic             out_1_valid;
  logic             out_1_ready;
  logic [WIDTH-1:0] out_1_data;
  logic [CNT_W-1:0] cnt_0;
  logic [CNT_W-1:0] cnt_1;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Behavioural model: one holding slot per destination plus a transfer tally.
  logic             m_full [2];
  logic [WIDTH-1:0] m_word [2];
  int               m_xfers[2];

  demux_32_1_2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_0_valid(out_0_valid),
    .out_0_ready(out_0_ready),
    .out_0_data (out_0_data),
    .out_1_valid(out_1_valid),
    .out_1_ready(out_1_ready),
    .out_1_data (out_1_data),
    .cnt_0      (cnt_0),
    .cnt_1      (cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual !== expected) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] expCount(input int k);
`ifdef DEMUX_CNT_EN
    return 32'(m_xfers[k] % (1 << CNT_W));
`else
    return 32'(k - k);
`endif
  endfunction

  // Drive one cycle of inputs, check all outputs before the edge, then advance the model.
  task automatic applyStimulus(input logic rst, input logic iv, input logic sel,
                               input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    logic rdy;
    logic rd[2];
    rst_n = rst; in_valid = iv; in_sel = sel; in_data = d;
    out_0_ready = r0; out_1_ready = r1;
    rd[0] = r0; rd[1] = r1;
    rdy = !m_full[sel] || rd[sel];
    #1;
    checkOutput("in_ready",    32'(in_ready),    32'(rdy));
    checkOutput("out_0_valid", 32'(out_0_valid), 32'(m_full[0]));
    checkOutput("out_1_valid", 32'(out_1_valid), 32'(m_full[1]));
    checkOutput("out_0_data",  out_0_data,       m_word[0]);
    checkOutput("out_1_data",  out_1_data,       m_word[1]);
    checkOutput("cnt_0",       32'(cnt_0),       expCount(0));
    checkOutput("cnt_1",       32'(cnt_1),       expCount(1));
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_full[k] = 1'b0; m_word[k] = '0; m_xfers[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic drained, loaded;
        drained = m_full[k] && rd[k];
        loaded  = iv && rdy && (int'(sel) == k);
        if (drained) m_xfers[k]++;
        if (loaded) begin
          m_full[k] = 1'b1; m_word[k] = d;
        end else if (drained) begin
          m_full[k] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 1'b0; m_word[k] = '0; m_xfers[k] = 0;
    end
    // First reset edge unchecked: the DUT registers are unknown before it.
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0000FFF0;
    out_0_ready = 1'b0; out_1_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000FFF0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000FFF0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Route to output 1 and stall it; the next word for output 1 must wait.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);

    // Back-to-back on output 0 with an always-ready consumer.
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Output 1 still stalled while output 0 takes a word.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h00F0F000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset while both are full, with a drain and an accept in the same cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Seventeen output-0 transfers wrap a 4-bit counter back to 1.
    for (int i = 0; i < 17; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, WIDTH'(32'hA000 + i), 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom),
                    WIDTH'($urandom),
                    1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 9) < 5));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/demux_32_1_2_reg.md
Name: demux_32_1_2_reg

Overview:
- Registered 32-bit 1-to-2 demultiplexer; the steering counterpart of the 2-to-1 datapath mux.
- Accepts one word per valid/ready handshake on a single input.
- Routes each accepted word to output 0 or output 1 according to a per-word select.
- Each output holds the word in a one-entry output register until the consumer takes it. Used wherever one pipeline-stage result must be delivered to one of two downstream consumers, e.g. a write-back path versus a store path.

Parameters:
- WIDTH, 32, data width of input and both outputs.
- CNT_W, 16, width of per-output transfer counters (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_sel  input  1  destination of the input word: 0 = output 0, 1 = output 1.
- in_data  input  WIDTH  input word.
- out_0_valid  output  1  output 0 register holds a word.
- out_0_ready  input  1  consumer 0 takes the word this cycle.
- out_0_data  output  WIDTH  output 0 word.
- out_1_valid  output  1  output 1 register holds a word.
- out_1_ready  input  1  consumer 1 takes the word this cycle.
- out_1_data  output  WIDTH  output 1 word.
- cnt_0  output  CNT_W  completed output-0 transfers (optional feature).
- cnt_1  output  CNT_W  completed output-1 transfers (optional feature).

Behaviour:
- Reset: when rst_n=0 at a rising edge, the following are cleared to 0:
  - out_0_valid, out_1_valid
  - out_0_data, out_1_data
  - cnt_0, cnt_1
  - Reset overrides any same-cycle accept or drain. A word held at reset is lost.
- Per-channel state k in {0,1}, two states:
  - EMPTY: out_k_valid=0.
  - FULL: out_k_valid=1.
- Output handshake: drain_k = out_k_valid & out_k_ready.
- in_ready is combinational:
  - in_ready = ~out_0_valid | out_0_ready when in_sel=0.
  - in_ready = ~out_1_valid | out_1_ready when in_sel=1.
  - in_ready does not depend on in_valid.
- Accept: acc = in_valid & in_ready. in_sel and in_data are sampled only when acc=1.
- Transitions for channel k, where load_k = acc & (in_sel==k):
  - EMPTY, load_k: go FULL; out_k_data <= in_data.
  - FULL, drain_k and no load_k: go EMPTY; out_k_data holds its last value.
  - FULL, drain_k and load_k: stay FULL; out_k_data <= in_data (back-to-back, no bubble).
  - FULL, no drain_k: stay FULL; data stable. in_ready=0 for words targeting k.
  - EMPTY, no load_k: stay EMPTY.
- Latency: an accepted word appears on out_k_valid/out_k_data on the cycle after acceptance. Throughput is 1 word per cycle per destination when the consumer is always ready.
- Blocking: a word waiting for a FULL, stalled channel does not block the other channel's words only if the producer changes in_sel. The block does no reordering or queuing beyond the one register per channel.
- out_k_valid and out_k_data change only on a load, a drain, or reset.
- in_valid=1 with in_ready=0: no state change; the producer holds in_data and in_sel.
- out_k_ready while EMPTY: ignored; no counter change.

Optional Feature:
- Macro DEMUX_CNT_EN.
- When defined:
  - cnt_k increments by 1 on every cycle with drain_k=1.
  - Modulo 2^CNT_W wrap: all-ones -> 0.
  - Cleared by reset.
- When not defined: cnt_0 and cnt_1 are tied to 0 and no counter registers are built. Port list is unchanged.

Test Plan:
- Reset: rst_n=0 for 2 cycles while in_valid=1, in_data=32'h0000FFF0 -> all outputs 0, no word loaded. After release, in_ready=1.
- Single route: in_sel=1, in_data=32'hFFFFFFFF accepted, out_1_ready=0 -> next cycle out_1_valid=1, out_1_data=32'hFFFFFFFF, out_0_valid=0. Next word with in_sel=1 sees in_ready=0 and is held.
- Back-to-back: out_0_ready=1, four accepts in_sel=0 with data 1,2,3,4 -> out_0_data equals 1,2,3,4 on consecutive cycles, out_0_valid continuously 1, no bubble.
- Independence: output 1 FULL and stalled; in_sel=0, in_data=32'h00F0F000 -> in_ready=1, out_0_data=32'h00F0F000 next cycle. out_1_data unchanged.
- Reset mid-operation: both channels FULL, rst_n=0 on the same cycle as out_0_ready=1 and a new accept -> both valids 0 next cycle, data 0, counters 0.
- DEMUX_CNT_EN with CNT_W=4: 17 output-0 transfers -> cnt_0=1 after wrap, cnt_1=0. Without the macro, cnt_0=0 throughout.
